// File: rtl/regbank_arb_pkg.sv
// Shared types for the register-bank arbiter controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regbank_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: picks one requester, one-hot, starting at ptr.
// Latency: 0 cycles (pure combinational, no state).
// Backpressure: none; the caller decides when the winner is actually used.
//
// Ports: req (request vector), ptr (search start index), winner (one-hot),
//        any_req (OR of req).
// Build option: REGBANK_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
//        wins) and ignores ptr; otherwise round robin starting at ptr.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic             any_req
);

    logic          found;
    logic [PW-1:0] idx;
`ifndef REGBANK_ARB_FIXED_PRIO_EN
    // One spare bit so ptr + offset cannot overflow before the wrap.
    logic [PW:0]   sum;
`endif

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
`ifdef REGBANK_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'(k);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
`else
        sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Wrap modulo N_REQ without a divider; N_REQ need not be 2^n.
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
`endif
    end

    assign any_req = |req;

endmodule

// File: rtl/regbank_arbiter_ctrl.sv
// Shared DEPTH x WIDTH register bank with one-access-per-grant arbitration and sequenced clear.
// Latency: req in cycle 0, gnt in cycle 1, write/rdata+rvalid in cycle 2; clear takes DEPTH cycles.
// Backpressure: requesters hold req until gnt; no grants during ACCESS or CLEAR (requests wait).
//
// Ports: clock/rst (async active-high); req/req_we/req_addr/req_wdata packed per
//        requester; gnt one-hot pulse; rdata/rvalid access result; clear_start,
//        clear_busy, clear_done for the bank clear.
// Build option: REGBANK_ARB_FIXED_PRIO_EN -> fixed priority, no rr pointer.
module regbank_arbiter_ctrl
    import regbank_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_we,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   clear_done
);

    localparam int PW = $clog2(N_REQ);

    state_t             state, state_nxt;
    logic               grant_en;
    logic               clr_enter;
    logic               clr_pend;
    logic [AW-1:0]      clr_idx;
    logic               clr_last;

    logic [N_REQ-1:0]   winner;
    logic               any_req;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      win_idx;

    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_wdata;

    logic               stg_we;
    logic [AW-1:0]      stg_addr;
    logic [WIDTH-1:0]   stg_wdata;
    logic               addr_ok;

    logic [WIDTH-1:0]   bank [DEPTH];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Mux the winning requester's operation into the staging inputs.
    always_comb begin
        win_idx   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner[k]) begin
                win_idx   = PW'(k);
                sel_we    = req_we[k];
                sel_addr  = req_addr[k*AW +: AW];
                sel_wdata = req_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    assign clr_last = (clr_idx == AW'(DEPTH-1));
    assign addr_ok  = ({1'b0, stg_addr} < (AW+1)'(DEPTH));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        clr_enter = 1'b0;
        case (state)
            ST_IDLE: begin
                // A clear (fresh or deferred from ACCESS) beats any request.
                if (clear_start || clr_pend) begin
                    state_nxt = ST_CLEAR;
                    clr_enter = 1'b1;
                end else if (any_req) begin
                    state_nxt = ST_ACCESS;
                    grant_en  = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef REGBANK_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            stg_we     <= 1'b0;
            stg_addr   <= '0;
            stg_wdata  <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            clr_pend   <= 1'b0;
            clr_idx    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            gnt        <= grant_en ? winner : '0;
            rvalid     <= (state == ST_ACCESS);
            clear_busy <= (state_nxt == ST_CLEAR);
            clear_done <= (state == ST_CLEAR) && clr_last;

            if (grant_en) begin
                stg_we    <= sel_we;
                stg_addr  <= sel_addr;
                stg_wdata <= sel_wdata;
            end

            // Out-of-range reads return zero rather than stale data.
            if (state == ST_ACCESS && !stg_we) begin
                rdata <= addr_ok ? bank[stg_addr] : '0;
            end

            // A clear arriving during ACCESS cannot be taken yet; remember it.
            if (clr_enter) begin
                clr_pend <= 1'b0;
            end else if (state == ST_ACCESS && clear_start) begin
                clr_pend <= 1'b1;
            end

            if (clr_enter) begin
                clr_idx <= '0;
            end else if (state == ST_CLEAR && !clr_last) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            bank[clr_idx] <= '0;
        end else if (state == ST_ACCESS && stg_we && addr_ok) begin
            bank[stg_addr] <= stg_wdata;
        end
    end

endmodule

// File: tb/tb_regbank_arbiter_ctrl.sv
module tb_regbank_arbiter_ctrl;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int AW  = 3;
    localparam int AW2 = 4;

    logic            clock = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we, gnt;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata;
    logic [W-1:0]    rdata;
    logic            rvalid, clear_start, clear_busy, clear_done;

    logic [N-1:0]     req2, req_we2, gnt2;
    logic [N*AW2-1:0] req_addr2;
    logic [N*W-1:0]   req_wdata2;
    logic [W-1:0]     rdata2;
    logic             rvalid2, clear_start2, clear_busy2, clear_done2;

    always #5 clock = ~clock;

    regbank_arbiter_ctrl dut (
        .clock(clock), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    regbank_arbiter_ctrl #(.DEPTH(10)) dut2 (
        .clock(clock), .rst(rst), .req(req2), .req_we(req_we2), .req_addr(req_addr2),
        .req_wdata(req_wdata2), .gnt(gnt2), .rdata(rdata2), .rvalid(rvalid2),
        .clear_start(clear_start2), .clear_busy(clear_busy2), .clear_done(clear_done2)
    );

    typedef struct {
        logic       is_rd;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          r;
        logic        we;
        logic [AW-1:0] a;
        logic [W-1:0]  wd;
        logic [W-1:0]  exp_rd;
        logic [N-1:0]  exp_gnt;
    } vec_t;
    vec_t tbl[9];

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    logic [N-1:0] exp_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called in the cycle where rvalid is due; pops the oldest expectation.
    task automatic sb_take(input string name);
        exp_t e;
        chk({name, " rvalid"}, 32'(rvalid), 32'd1);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: rvalid with empty scoreboard, got 1 expected 0", name);
        end else begin
            e = sb.pop_front();
            if (e.is_rd) chk({name, " rdata"}, 32'(rdata), 32'(e.data));
        end
    endtask

    task automatic issue_op(input int r, input logic we, input logic [AW-1:0] a,
                            input logic [W-1:0] wd, input logic [W-1:0] exp_rd,
                            input logic [N-1:0] exp_gnt, input string name);
        @(posedge clock); #1;
        req = '0;
        req[r] = 1'b1;
        req_we[r] = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*W +: W] = wd;
        sb.push_back('{is_rd: !we, data: exp_rd});
        @(posedge clock); @(negedge clock);
        chk({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
        @(posedge clock); #1;
        req = '0;
        @(negedge clock);
        sb_take(name);
    endtask

    task automatic issue_op2(input logic we, input logic [AW2-1:0] a, input logic [W-1:0] wd,
                             input logic [W-1:0] exp_rd, input string name);
        @(posedge clock); #1;
        req2 = 4'b0001;
        req_we2[0] = we;
        req_addr2[AW2-1:0] = a;
        req_wdata2[W-1:0] = wd;
        @(posedge clock); @(negedge clock);
        chk({name, " gnt"}, 32'(gnt2), 32'h1);
        @(posedge clock); #1;
        req2 = '0;
        @(negedge clock);
        chk({name, " rvalid"}, 32'(rvalid2), 32'd1);
        if (!we) chk({name, " rdata"}, 32'(rdata2), 32'(exp_rd));
    endtask

    initial begin
        tbl[0] = '{3, 1'b0, 3'd3, 8'h00, 8'h00, 4'b1000};
        tbl[1] = '{1, 1'b1, 3'd2, 8'hA5, 8'h00, 4'b0010};
        tbl[2] = '{3, 1'b0, 3'd2, 8'h00, 8'hA5, 4'b1000};
        tbl[3] = '{0, 1'b1, 3'd7, 8'h3C, 8'h00, 4'b0001};
        tbl[4] = '{2, 1'b0, 3'd7, 8'h00, 8'h3C, 4'b0100};
        tbl[5] = '{1, 1'b1, 3'd0, 8'h5A, 8'h00, 4'b0010};
        tbl[6] = '{0, 1'b0, 3'd0, 8'h00, 8'h5A, 4'b0001};
        tbl[7] = '{2, 1'b1, 3'd2, 8'h11, 8'h00, 4'b0100};
        tbl[8] = '{3, 1'b0, 3'd2, 8'h00, 8'h11, 4'b1000};

        rst = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
        req2 = '0; req_we2 = '0; req_addr2 = '0; req_wdata2 = '0; clear_start2 = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock) rst = 1'b0;
        @(negedge clock);
        chk("reset outputs", 32'({gnt, rdata, rvalid, clear_busy, clear_done}), 32'd0);
        chk("reset outputs dut2", 32'({gnt2, rdata2, rvalid2, clear_busy2, clear_done2}), 32'd0);

        // Single accesses from a table of vectors.
        for (int i = 0; i < 9; i++) begin
            issue_op(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].exp_rd,
                     tbl[i].exp_gnt, $sformatf("vec%0d", i));
        end

        // All requesters hold req (reads of addr 0 = 5A); pointer is 0 here.
        @(posedge clock); #1;
        req = '1; req_we = '0; req_addr = '0;
        for (int k = 0; k < 5; k++) begin
`ifdef REGBANK_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'(1 << (k % N));
`endif
            @(posedge clock); @(negedge clock);
            chk($sformatf("rr gnt%0d", k), 32'(gnt), 32'(exp_g));
            sb.push_back('{is_rd: 1'b1, data: 8'h5A});
            @(posedge clock); @(negedge clock);
            chk($sformatf("rr gap%0d", k), 32'(gnt), 32'd0);
            sb_take($sformatf("rr read%0d", k));
        end
        req = '0;

        // Fill bank, then clear with req[2] waiting throughout.
        for (int a = 0; a < 8; a++) begin
            issue_op(0, 1'b1, 3'(a), 8'hFF, 8'h00, 4'b0001, $sformatf("fill%0d", a));
        end
        @(posedge clock); #1;
        clear_start = 1'b1;
        req = 4'b0100; req_we = '0; req_addr[2*AW +: AW] = 3'd5;
        sb.push_back('{is_rd: 1'b1, data: 8'h00});
        @(posedge clock); #1;
        clear_start = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (clear_busy) begin
                busy_cnt++;
                chk("gnt during clear", 32'(gnt), 32'd0);
            end else break;
        end
        chk("clear busy cycles", 32'(busy_cnt), 32'd8);
        chk("clear_done pulse", 32'(clear_done), 32'd1);
        chk("no gnt in first idle", 32'(gnt), 32'd0);
        @(negedge clock);
        chk("held req gnt after clear", 32'(gnt), 32'b0100);
        chk("clear_done single cycle", 32'(clear_done), 32'd0);
        @(posedge clock); #1;
        req = '0;
        @(negedge clock);
        sb_take("held read");
        for (int a = 0; a < 8; a++) begin
            issue_op(1, 1'b0, 3'(a), 8'h00, 8'h00, 4'b0010, $sformatf("cleared%0d", a));
        end

        // clear_start during a read's ACCESS, then again mid-clear.
        issue_op(0, 1'b1, 3'd1, 8'h77, 8'h00, 4'b0001, "coll write");
        @(posedge clock); #1;
        req = 4'b0001; req_we = '0; req_addr[AW-1:0] = 3'd1;
        sb.push_back('{is_rd: 1'b1, data: 8'h77});
        @(posedge clock); #1;
        req = '0; clear_start = 1'b1;
        @(negedge clock);
        chk("coll gnt", 32'(gnt), 32'b0001);
        @(posedge clock); #1;
        clear_start = 1'b0;
        @(negedge clock);
        sb_take("coll read");
        chk("coll busy before clear", 32'(clear_busy), 32'd0);
        @(negedge clock);
        chk("coll busy starts", 32'(clear_busy), 32'd1);
        busy_cnt = 1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock); #1;
            clear_start = (busy_cnt == 3);
            @(negedge clock);
            if (clear_busy) busy_cnt++;
            else break;
        end
        clear_start = 1'b0;
        chk("coll busy cycles", 32'(busy_cnt), 32'd8);
        chk("coll clear_done", 32'(clear_done), 32'd1);
        issue_op(2, 1'b0, 3'd1, 8'h00, 8'h00, 4'b0100, "coll cleared");

        // Reset in clear cycle 4: entry 7 is not yet reached by the clear.
        issue_op(0, 1'b1, 3'd7, 8'h99, 8'h00, 4'b0001, "pre-rst write");
        @(posedge clock); #1;
        clear_start = 1'b1;
        @(posedge clock); #1;
        clear_start = 1'b0;
        repeat (4) @(negedge clock);
        rst = 1'b1;
        #1;
        chk("rst mid-clear outputs", 32'({gnt, rdata, rvalid, clear_busy, clear_done}), 32'd0);
        @(negedge clock);
        @(negedge clock) rst = 1'b0;
        @(negedge clock);
        chk("after rst busy", 32'(clear_busy), 32'd0);
        // Pointer was 1 before reset; back at 0 requester 0 must beat 3.
        @(posedge clock); #1;
        req = 4'b1001; req_we = '0;
        req_addr[0 +: AW] = 3'd7; req_addr[3*AW +: AW] = 3'd7;
        sb.push_back('{is_rd: 1'b1, data: 8'h00});
        @(posedge clock); @(negedge clock);
        chk("post-rst gnt ptr0", 32'(gnt), 32'b0001);
        @(posedge clock); #1;
        req = 4'b1000;
        sb.push_back('{is_rd: 1'b1, data: 8'h00});
        @(negedge clock);
        sb_take("post-rst read0");
        @(negedge clock);
        chk("post-rst gnt r3", 32'(gnt), 32'b1000);
        @(posedge clock); #1;
        req = '0;
        @(negedge clock);
        sb_take("post-rst read3");

        // Address boundaries on the DEPTH=10 instance.
        issue_op2(1'b1, 4'd9,  8'h42, 8'h00, "b wr9");
        issue_op2(1'b0, 4'd9,  8'h00, 8'h42, "b rd9");
        issue_op2(1'b1, 4'd10, 8'h55, 8'h00, "b wr10");
        issue_op2(1'b0, 4'd10, 8'h00, 8'h00, "b rd10");
        issue_op2(1'b1, 4'd15, 8'h66, 8'h00, "b wr15");
        issue_op2(1'b0, 4'd15, 8'h00, 8'h00, "b rd15");
        issue_op2(1'b0, 4'd2,  8'h00, 8'h00, "b rd2");
        issue_op2(1'b0, 4'd9,  8'h00, 8'h42, "b rd9 again");

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
